board_state_ctrl: RTL

BOARD_STATE_CTRL -- requirements
Module: board_state_ctrl

---
 rtl/ttt_pkg.sv | 50 +++++
 rtl/ttt_line_check.sv | 23 ++
 rtl/board_state_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe board controller: tile and result
// encodings, controller state type, and the eight winning line triples.
package ttt_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      BLUE  = 2'b10,
      RED   = 2'b11
   } tile_e;

   typedef enum logic [1:0] {
      RES_PLAY = 2'b00,
      RES_DRAW = 2'b01,
      RES_BLUE = 2'b10,
      RES_RED  = 2'b11
   } result_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int NUM_TILES = 9;
   localparam int NUM_LINES = 8;

   // Rows, columns, then the two diagonals; tile indices are row-major.
   localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
      '{4'd0, 4'd1, 4'd2},
      '{4'd3, 4'd4, 4'd5},
      '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6},
      '{4'd1, 4'd4, 4'd7},
      '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8},
      '{4'd2, 4'd4, 4'd6}
   };

   // Tile code at index idx; indices beyond the board read as empty.
   function automatic logic [1:0] tile_at(input logic [17:0] board,
                                          input logic [3:0]  idx);
      logic [1:0] t;
      t = EMPTY;
      for (int i = 0; i < NUM_TILES; i++) begin
         if (idx == 4'(i)) t = board[2*i +: 2];
      end
      return t;
   endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational win detector: flags whether any of the eight lines is fully
// owned by the given colour on the given board.
module ttt_line_check
   import ttt_pkg::*;
(
   input  logic [17:0] board_i,
   input  logic [1:0]  colour_i,
   output logic        win_o
);

   // OR of all eight three-in-a-row matches for colour_i.
   always_comb begin
      win_o = 1'b0;
      for (int l = 0; l < NUM_LINES; l++) begin
         if ((tile_at(board_i, WIN_LINES[l][0]) == colour_i) &&
             (tile_at(board_i, WIN_LINES[l][1]) == colour_i) &&
             (tile_at(board_i, WIN_LINES[l][2]) == colour_i)) begin
            win_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/board_state_ctrl.sv
// Tic-tac-toe board state controller. Accepts moves over a valid/ready
// handshake, writes the mover's colour, then spends one CHECK cycle deciding
// win / draw / next turn. Win detection is built only when TTT_WIN_DETECT_EN
// is defined; otherwise games end only in a draw on the ninth move.
//
// Handshake: a move is taken at a rising edge where move_valid && move_ready
// && !new_game. move_ready is high only in IDLE. Exactly one of move_ack
// (legal, tile written) or move_err (rejected, nothing changed) pulses for one
// cycle after each taken move. new_game outranks the handshake and drops any
// simultaneous move silently; reset outranks everything.
module board_state_ctrl
   import ttt_pkg::*;
#(
   parameter logic FIRST_RED = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        new_game,
   input  logic        move_valid,
   input  logic [3:0]  move_pos,
   output logic        move_ready,
   output logic        move_ack,
   output logic        move_err,
   output logic [17:0] boardArr,
   output logic        turn_red,
   output logic [1:0]  result,
   output logic [3:0]  move_count,
   output state_e      state_dbg_o
);

   state_e      state_q, state_d;
   logic [17:0] board_q, board_d;
   logic        turn_red_q, turn_red_d;
   result_e     result_q, result_d;
   logic [3:0]  count_q, count_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;

   logic        tile_free;
   tile_e       mover_colour;
   logic        line_win;

   assign mover_colour = turn_red_q ? RED : BLUE;

   // Requested tile is on the board and empty; out-of-range positions stay 0.
   always_comb begin
      tile_free = 1'b0;
      for (int i = 0; i < NUM_TILES; i++) begin
         if (move_pos == 4'(i)) tile_free = (board_q[2*i +: 2] == EMPTY);
      end
   end

`ifdef TTT_WIN_DETECT_EN
   // Board already holds the new tile during CHECK, so test the mover's colour.
   ttt_line_check u_line_check (
      .board_i  (board_q),
      .colour_i (mover_colour),
      .win_o    (line_win)
   );
`else
   assign line_win = 1'b0;
`endif

   // Next-state and next-output logic for the IDLE/CHECK/DONE controller.
   always_comb begin
      state_d    = state_q;
      board_d    = board_q;
      turn_red_d = turn_red_q;
      result_d   = result_q;
      count_d    = count_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      if (new_game) begin
         state_d    = IDLE;
         board_d    = '0;
         turn_red_d = FIRST_RED;
         result_d   = RES_PLAY;
         count_d    = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (move_valid) begin
                  if (tile_free) begin
                     for (int i = 0; i < NUM_TILES; i++) begin
                        if (move_pos == 4'(i)) board_d[2*i +: 2] = mover_colour;
                     end
                     count_d = count_q + 4'd1;
                     ack_d   = 1'b1;
                     state_d = CHECK;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            CHECK: begin
               // A ninth move that completes a line is a win, not a draw.
               if (line_win) begin
                  result_d = turn_red_q ? RES_RED : RES_BLUE;
                  state_d  = DONE;
               end else if (count_q == 4'd9) begin
                  result_d = RES_DRAW;
                  state_d  = DONE;
               end else begin
                  turn_red_d = ~turn_red_q;
                  state_d    = IDLE;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and output registers; synchronous active-high reset wins over all.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         board_q    <= '0;
         turn_red_q <= FIRST_RED;
         result_q   <= RES_PLAY;
         count_q    <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         board_q    <= board_d;
         turn_red_q <= turn_red_d;
         result_q   <= result_d;
         count_q    <= count_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
      end
   end

   assign move_ready  = (state_q == IDLE);
   assign move_ack    = ack_q;
   assign move_err    = err_q;
   assign boardArr    = board_q;
   assign turn_red    = turn_red_q;
   assign result      = result_q;
   assign move_count  = count_q;
   assign state_dbg_o = state_q;

endmodule
